// File: rtl/fpu_seq_ctrl.sv
// fpu_seq_ctrl: multi-cycle sequencer for the FP unit of a single-cycle core.
// Freezes PC/instruction while an FP op executes, pulses FPUEn on accept and
// ResultWE/FlagsWE on write-back. Optional stall-cycle counter is built when
// the macro FPU_SEQ_CTRL_PERF_EN is defined; otherwise StallCount is 0.
module fpu_seq_ctrl #(
    parameter int unsigned ADD_LAT = 2,
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned DIV_LAT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        FPUOp,
    input  logic [1:0]  FPUControlIn,
    input  logic        RegWriteIn,
    input  logic        FlagWriteIn,
    input  logic        Flush,
    output logic        Stall,
    output logic        FPUEn,
    output logic [1:0]  FPUControl,
    output logic        ResultWE,
    output logic        FlagsWE,
    output logic        Busy,
    output logic [31:0] StallCount
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned SC_W  = 32;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;

    // Latencies must fit the 4-bit down-counter and be at least one cycle
    if (ADD_LAT < 1 || ADD_LAT > 15) begin : g_add_lat_bad
        $error("fpu_seq_ctrl: ADD_LAT out of range 1..15");
    end
    if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_mul_lat_bad
        $error("fpu_seq_ctrl: MUL_LAT out of range 1..15");
    end
    if (DIV_LAT < 1 || DIV_LAT > 15) begin : g_div_lat_bad
        $error("fpu_seq_ctrl: DIV_LAT out of range 1..15");
    end

    logic [1:0]       r_state;
    logic [1:0]       r_op;
    logic [CNT_W-1:0] r_count;
    logic             r_rw;
    logic             r_fw;

    logic [1:0]       w_next_state;
    logic [1:0]       w_next_op;
    logic [CNT_W-1:0] w_next_count;
    logic             w_next_rw;
    logic             w_next_fw;
    logic [CNT_W-1:0] w_lat_m1;

    // Initial count for the incoming op (latency minus one)
    always_comb begin
        w_lat_m1 = CNT_W'(ADD_LAT - 1);
        case (FPUControlIn)
            2'b10:   w_lat_m1 = CNT_W'(MUL_LAT - 1);
            2'b11:   w_lat_m1 = CNT_W'(DIV_LAT - 1);
            default: w_lat_m1 = CNT_W'(ADD_LAT - 1);
        endcase
    end

    // Next-state and output decode
    always_comb begin
        w_next_state = r_state;
        w_next_op    = r_op;
        w_next_count = r_count;
        w_next_rw    = r_rw;
        w_next_fw    = r_fw;
        Stall        = 1'b0;
        FPUEn        = 1'b0;
        ResultWE     = 1'b0;
        FlagsWE      = 1'b0;
        Busy         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (FPUOp && !Flush) begin
                    Stall        = 1'b1;
                    FPUEn        = 1'b1;
                    w_next_op    = FPUControlIn;
                    w_next_rw    = RegWriteIn;
                    w_next_fw    = FlagWriteIn;
                    w_next_count = w_lat_m1;
                    w_next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                Stall = 1'b1;
                Busy  = 1'b1;
                if (Flush) begin
                    w_next_state = S_IDLE;
                end else if (r_count == '0) begin
                    w_next_state = S_WB;
                end else begin
                    w_next_count = r_count - CNT_W'(1);
                end
            end
            S_WB: begin
                // FPUOp is still high here for the same instruction; ignored
                Busy         = 1'b1;
                ResultWE     = r_rw & ~Flush;
                FlagsWE      = r_fw & ~Flush;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State and latched-operation registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_op    <= 2'b00;
            r_count <= '0;
            r_rw    <= 1'b0;
            r_fw    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_op    <= w_next_op;
            r_count <= w_next_count;
            r_rw    <= w_next_rw;
            r_fw    <= w_next_fw;
        end
    end

    assign FPUControl = r_op;

`ifdef FPU_SEQ_CTRL_PERF_EN
    logic [SC_W-1:0] r_stall_cnt;

    // Saturating count of stalled cycles; cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (Stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + SC_W'(1);
        end
    end

    assign StallCount = r_stall_cnt;
`else
    assign StallCount = SC_W'(0);
`endif

endmodule

// File: tb/tb_fpu_seq_ctrl.sv
// Testbench for fpu_seq_ctrl: driver pushes per-cycle expected outputs from an
// instruction-timeline model into a queue; a monitor pops and compares.
module tb_fpu_seq_ctrl;

    localparam int unsigned ADD_L = 2;
    localparam int unsigned MUL_L = 3;
    localparam int unsigned DIV_L = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        FPUOp;
    logic [1:0]  FPUControlIn;
    logic        RegWriteIn;
    logic        FlagWriteIn;
    logic        Flush;
    logic        Stall;
    logic        FPUEn;
    logic [1:0]  FPUControl;
    logic        ResultWE;
    logic        FlagsWE;
    logic        Busy;
    logic [31:0] StallCount;

    fpu_seq_ctrl #(.ADD_LAT(ADD_L), .MUL_LAT(MUL_L), .DIV_LAT(DIV_L)) dut (
        .clk(clk), .reset(reset), .FPUOp(FPUOp), .FPUControlIn(FPUControlIn),
        .RegWriteIn(RegWriteIn), .FlagWriteIn(FlagWriteIn), .Flush(Flush),
        .Stall(Stall), .FPUEn(FPUEn), .FPUControl(FPUControl),
        .ResultWE(ResultWE), .FlagsWE(FlagsWE), .Busy(Busy),
        .StallCount(StallCount)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        chk;
        logic        st;
        logic        en;
        logic [1:0]  ctl;
        logic        rwe;
        logic        fwe;
        logic        bsy;
        logic [31:0] sc;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic tb_done = 1'b0;

    // Reference model: one in-flight instruction described by its accept cycle
    int          m_cyc  = 0;
    logic        m_busy = 1'b0;
    int          m_ta   = 0;
    int          m_lat  = 0;
    logic [1:0]  m_op   = 2'b00;
    logic        m_rw   = 1'b0;
    logic        m_fw   = 1'b0;
    logic [31:0] m_sc   = 32'd0;

    function automatic int lat_of(input logic [1:0] c);
        case (c)
            2'b10:   return int'(MUL_L);
            2'b11:   return int'(DIV_L);
            default: return int'(ADD_L);
        endcase
    endfunction

    task automatic step(input logic op_i, input logic [1:0] ctl_i,
                        input logic rw_i, input logic fw_i, input logic fl_i,
                        input logic rs_i, input logic chk_i,
                        input logic sc_fix, input logic [31:0] sc_val);
        exp_t e;
        logic acc;
        logic rs;
        int   wbc;
        @(posedge clk);
        #1;
        wbc = m_ta + 1 + m_lat;
        // keep reset away from the write-back cycle
        rs  = rs_i & ~(m_busy && (m_cyc == wbc));
        reset        = rs;
        FPUOp        = op_i;
        FPUControlIn = ctl_i;
        RegWriteIn   = rw_i;
        FlagWriteIn  = fw_i;
        Flush        = fl_i;
        e     = '0;
        e.chk = chk_i;
        e.ctl = m_op;
        if (m_busy) begin
            e.bsy = 1'b1;
            if (m_cyc < wbc) begin
                e.st = 1'b1;
            end else begin
                e.rwe = m_rw & ~fl_i;
                e.fwe = m_fw & ~fl_i;
            end
        end
        acc = !m_busy && op_i && !fl_i;
        if (acc) begin
            e.st = 1'b1;
            e.en = 1'b1;
        end
`ifdef FPU_SEQ_CTRL_PERF_EN
        e.sc = m_sc;
`else
        e.sc = 32'd0;
`endif
        if (sc_fix) e.sc = sc_val;
        q.push_back(e);
        if (rs) begin
            m_busy = 1'b0;
            m_op   = 2'b00;
            m_sc   = 32'd0;
        end else begin
            if (e.st && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 32'd1;
            if (m_busy) begin
                if (fl_i || m_cyc == wbc) m_busy = 1'b0;
            end else if (acc) begin
                m_busy = 1'b1;
                m_ta   = m_cyc;
                m_lat  = lat_of(ctl_i);
                m_op   = ctl_i;
                m_rw   = rw_i;
                m_fw   = fw_i;
            end
        end
        m_cyc = m_cyc + 1;
    endtask

    task automatic ist(input logic op_i, input logic [1:0] ctl_i,
                       input logic rw_i, input logic fw_i, input logic fl_i,
                       input logic rs_i);
        step(op_i, ctl_i, rw_i, fw_i, fl_i, rs_i, 1'b1, 1'b0, 32'd0);
    endtask

    // Reset-state check: all outputs at their reset values
    task automatic chk_reset_state();
        @(negedge clk);
        vectors++;
        if (Stall !== 1'b0 || FPUEn !== 1'b0 || FPUControl !== 2'b00 ||
            ResultWE !== 1'b0 || FlagsWE !== 1'b0 || Busy !== 1'b0 ||
            StallCount !== 32'd0) begin
            miscompares++;
            $display("FAIL reset state t=%0t st=%b en=%b ctl=%b rwe=%b fwe=%b bsy=%b sc=%0d",
                     $time, Stall, FPUEn, FPUControl, ResultWE, FlagsWE, Busy, StallCount);
        end
    endtask

    // Monitor: compare DUT outputs against the expected entry for this cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                if (e.chk) begin
                    vectors++;
                    if (Stall !== e.st || FPUEn !== e.en || FPUControl !== e.ctl ||
                        ResultWE !== e.rwe || FlagsWE !== e.fwe || Busy !== e.bsy ||
                        StallCount !== e.sc) begin
                        miscompares++;
                        $display("FAIL outputs t=%0t act st=%b en=%b ctl=%b rwe=%b fwe=%b bsy=%b sc=%0d req st=%b en=%b ctl=%b rwe=%b fwe=%b bsy=%b sc=%0d",
                                 $time, Stall, FPUEn, FPUControl, ResultWE, FlagsWE, Busy, StallCount,
                                 e.st, e.en, e.ctl, e.rwe, e.fwe, e.bsy, e.sc);
                    end
                end
            end
        end
    end

    // Watchdog: the stimulus must complete within the time bound
    initial begin
        #2000000;
        if (tb_done !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout t=%0t: wait expired, %0d vectors, %0d miscompares",
                     $time, vectors, miscompares);
            $finish;
        end
    end

    initial begin
        logic       r_op_i;
        logic [1:0] r_ctl;
        logic       r_rs;
        reset = 1'b1; FPUOp = 1'b0; FPUControlIn = 2'b00;
        RegWriteIn = 1'b0; FlagWriteIn = 1'b0; Flush = 1'b0;

        // Reset; first cycle is before any edge so it is not checked
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        ist(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        ist(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_reset_state();

        // FADD held for its whole occupancy, RegWrite only
        repeat (4) ist(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        ist(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // FDIV with flag write
        repeat (10) ist(1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
        ist(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Two FMULs back-to-back
        repeat (10) ist(1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
        ist(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // FDIV flushed at T+2
        repeat (2) ist(1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
        ist(1'b1, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
        ist(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        ist(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // FMUL interrupted by reset mid-EXEC
        repeat (2) ist(1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
        ist(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        ist(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_reset_state();

        // Integer instructions only
        repeat (20) ist(1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 1'b0, 1'b0);

        // Stall counter after FADD + FDIV from a fresh reset
        ist(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (4)  ist(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (10) ist(1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
`ifdef FPU_SEQ_CTRL_PERF_EN
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd12);
`else
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0);
`endif

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 1500; i++) begin
            r_op_i = ($urandom_range(0, 3) != 0);
            r_ctl  = 2'($urandom_range(0, 3));
            r_rs   = ($urandom_range(0, 63) == 0);
            if (r_rs) r_op_i = 1'b0;
            ist(r_op_i, r_ctl, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 15) == 0), r_rs);
        end

        @(negedge clk);
        #1;
        tb_done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
